sram_rd_slave: RTL and testbench

Slave-side AXI read-channel front end that consumes the address/control stream the interconnect's read-address router drives onto one slave port (ARID_S/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID). It accepts one read burst at a time, generates per-beat word addresses for a synchronous single-port SRAM with one-cycle read latency, and returns data on the R channel with correct RID_S, RRESP and RLAST. One instance sits in front of each SRAM-backed slave (ROM, IM, DM, DRAM shadow).

---
 rtl/axi_pkg.sv | 20 ++
 rtl/rd_addr_gen.sv | 33 +++
 rtl/sram_rd_slave.sv | 132 +++++++++++++
 tb/tb_sram_rd_slave.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// AXI read-side encodings and widths used by the SRAM read slave.
package axi_pkg;

  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_LEN_BITS  = 4;
  localparam int AXI_SIZE_BITS = 3;
  localparam int AXI_DATA_BITS = 32;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} rd_state_t;

endpackage

// File: rtl/rd_addr_gen.sv
// Next SRAM word address for an AXI burst (FIXED / INCR / WRAP).
module rd_addr_gen
  import axi_pkg::*;
#(
  parameter int MEM_ADDR_W = 14
) (
  input  logic [MEM_ADDR_W-1:0]   addr_i,
  input  logic [AXI_LEN_BITS-1:0] len_i,
  input  logic [1:0]              burst_i,
  output logic [MEM_ADDR_W-1:0]   next_addr_o
);

  logic [MEM_ADDR_W-1:0] inc;
  logic [MEM_ADDR_W-1:0] mask;
  logic                  wrap_ok;

  // ARLEN+1 is a power of two for the legal wrap lengths, so ARLEN itself
  // is the mask of the address bits that roll over.
  assign inc     = addr_i + {{(MEM_ADDR_W-1){1'b0}}, 1'b1};
  assign mask    = {{(MEM_ADDR_W-AXI_LEN_BITS){1'b0}}, len_i};
  assign wrap_ok = (len_i == 4'd1) || (len_i == 4'd3) || (len_i == 4'd7) || (len_i == 4'd15);

  // Select the address update rule; illegal wrap lengths fall back to INCR.
  always_comb begin
    next_addr_o = inc;
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP:  if (wrap_ok) next_addr_o = (addr_i & ~mask) | (inc & mask);
      default:     next_addr_o = inc;
    endcase
  end

endmodule

// File: rtl/sram_rd_slave.sv
// AXI read slave in front of a one-cycle-latency synchronous SRAM.
// One burst at a time; each beat costs an ADDR cycle (SRAM access) and a
// DATA cycle (beat presented on R until RREADY).
module sram_rd_slave
  import axi_pkg::*;
#(
  parameter int MEM_ADDR_W = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AXI_IDS_BITS-1:0]  ARID_S,
  input  logic [AXI_ADDR_BITS-1:0] ARADDR,
  input  logic [AXI_LEN_BITS-1:0]  ARLEN,
  input  logic [AXI_SIZE_BITS-1:0] ARSIZE,
  input  logic [1:0]               ARBURST,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [AXI_IDS_BITS-1:0]  RID_S,
  output logic [AXI_DATA_BITS-1:0] RDATA,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  output logic                     RVALID,
  input  logic                     RREADY,
  output logic                     mem_cs,
  output logic                     mem_oe,
  output logic [MEM_ADDR_W-1:0]    mem_addr,
  input  logic [AXI_DATA_BITS-1:0] mem_dout
);

  rd_state_t               state_q;
  logic                    arready_q;
  logic [AXI_IDS_BITS-1:0] id_q;
  logic [MEM_ADDR_W-1:0]   addr_q;
  logic [MEM_ADDR_W-1:0]   addr_d;
  logic [AXI_LEN_BITS-1:0] len_q;
  logic [AXI_LEN_BITS-1:0] cnt_q;
  logic [1:0]              burst_q;
  logic [1:0]              resp_q;
  logic                    rvalid_q;
  logic                    rlast_q;
  logic                    cs_q;
  logic                    fresh_q;
  logic [AXI_DATA_BITS-1:0] rdata_q;

  // Sub-word sizes and byte-offset bits carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ARSIZE, ARADDR[AXI_ADDR_BITS-1:MEM_ADDR_W+2], ARADDR[1:0]};

  rd_addr_gen #(.MEM_ADDR_W(MEM_ADDR_W)) u_addr_gen (
    .addr_i      (addr_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (addr_d)
  );

  // Burst FSM: accept AR, strobe SRAM, present beat, advance address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      burst_q   <= BURST_FIXED;
      resp_q    <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      cs_q      <= 1'b0;
      fresh_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      cs_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ARVALID && arready_q) begin
            arready_q <= 1'b0;
            id_q      <= ARID_S;
            addr_q    <= ARADDR[MEM_ADDR_W+1:2];
            len_q     <= ARLEN;
            // Reserved burst type runs as INCR but is flagged on every beat.
            burst_q   <= (ARBURST == BURST_RSVD) ? BURST_INCR : ARBURST;
            resp_q    <= (ARBURST == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
            cnt_q     <= '0;
            cs_q      <= 1'b1;
            state_q   <= ADDR;
          end else begin
            arready_q <= 1'b1;
          end
        end
        ADDR: begin
          rvalid_q <= 1'b1;
          rlast_q  <= (cnt_q == len_q);
          fresh_q  <= 1'b1;
          state_q  <= DATA;
        end
        DATA: begin
          // SRAM data arrives during the first DATA cycle; hold it from then on.
          if (fresh_q) begin
            rdata_q <= mem_dout;
            fresh_q <= 1'b0;
          end
          if (RREADY) begin
            rvalid_q <= 1'b0;
            if (rlast_q) begin
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              cnt_q   <= cnt_q + {{(AXI_LEN_BITS-1){1'b0}}, 1'b1};
              addr_q  <= addr_d;
              cs_q    <= 1'b1;
              state_q <= ADDR;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ARREADY  = arready_q;
  assign RID_S    = id_q;
  assign RRESP    = resp_q;
  assign RLAST    = rlast_q;
  assign RVALID   = rvalid_q;
  assign RDATA    = fresh_q ? mem_dout : rdata_q;
  assign mem_cs   = cs_q;
  assign mem_oe   = cs_q;
  assign mem_addr = addr_q;

endmodule

// File: tb/tb_sram_rd_slave.sv
// Directed table-driven bench for sram_rd_slave with a behavioural SRAM.
module tb_sram_rd_slave;
  localparam int AW = 14;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ARID_S;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [7:0]  RID_S;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        mem_cs;
  logic        mem_oe;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_dout;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sram_rd_slave #(.MEM_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .ARID_S(ARID_S), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID_S(RID_S), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY), .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_addr(mem_addr),
    .mem_dout(mem_dout)
  );

  function automatic logic [31:0] pat(input logic [AW-1:0] a);
    return {8'hD0, a[7:0] ^ 8'h5A, 2'b00, a};
  endfunction

  // Synchronous SRAM: data for the strobed address appears the next cycle.
  always @(posedge clk) if (mem_cs) mem_dout <= pat(mem_addr);

  typedef struct {
    logic [1:0]         burst;
    logic [31:0]        addr;
    logic [3:0]         len;
    logic [2:0]         size;
    logic [7:0]         id;
    logic [3:0][AW-1:0] ea;
    logic [1:0]         resp;
    int                 sb;
    int                 sc;
    bit                 mav;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] burst, input logic [31:0] addr,
                              input logic [3:0] len, input logic [2:0] size,
                              input logic [7:0] id, input int e0, input int e1,
                              input int e2, input int e3, input logic [1:0] resp,
                              input int sb, input int sc, input bit mav);
    vec_t v;
    v.burst = burst; v.addr = addr; v.len = len; v.size = size; v.id = id;
    v.ea[0] = AW'(e0); v.ea[1] = AW'(e1); v.ea[2] = AW'(e2); v.ea[3] = AW'(e3);
    v.resp = resp; v.sb = sb; v.sc = sc; v.mav = mav;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_burst(input vec_t v);
    int w;
    logic [31:0] hd;
    w = 0;
    while (ARREADY !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    chk("arready_idle", {31'b0, ARREADY}, 1);
    ARID_S = v.id; ARADDR = v.addr; ARLEN = v.len; ARSIZE = v.size;
    ARBURST = v.burst; ARVALID = 1'b1; RREADY = 1'b1;
    @(posedge clk); #1;
    if (!v.mav) ARVALID = 1'b0;
    else ARADDR = 32'h0000_0100;
    for (int b = 0; b <= int'(v.len); b++) begin
      @(negedge clk);
      chk("mem_cs", {31'b0, mem_cs}, 1);
      chk("mem_oe", {31'b0, mem_oe}, 1);
      chk("mem_addr", {18'b0, mem_addr}, {18'b0, v.ea[b]});
      chk("rvalid_in_addr", {31'b0, RVALID}, 0);
      if (v.mav) chk("arready_busy", {31'b0, ARREADY}, 0);
      @(negedge clk);
      chk("rvalid", {31'b0, RVALID}, 1);
      chk("rdata", RDATA, pat(v.ea[b]));
      chk("rid", {24'b0, RID_S}, {24'b0, v.id});
      chk("rresp", {30'b0, RRESP}, {30'b0, v.resp});
      chk("rlast", {31'b0, RLAST}, {31'b0, (b == int'(v.len))});
      chk("cs_in_data", {31'b0, mem_cs}, 0);
      if (v.mav) chk("arready_busy", {31'b0, ARREADY}, 0);
      if (b == v.sb) begin
        hd = pat(v.ea[b]);
        RREADY = 1'b0;
        repeat (v.sc) begin
          @(negedge clk);
          chk("stall_rvalid", {31'b0, RVALID}, 1);
          chk("stall_rdata", RDATA, hd);
          chk("stall_rlast", {31'b0, RLAST}, {31'b0, (b == int'(v.len))});
          chk("stall_cs", {31'b0, mem_cs}, 0);
        end
        RREADY = 1'b1;
      end
      if (b == int'(v.len)) ARVALID = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    chk("arready_after", {31'b0, ARREADY}, 1);
    chk("rvalid_after", {31'b0, RVALID}, 0);
  endtask

  vec_t vecs [9];

  initial begin
    vecs[0] = mk(2'b01, 32'h10,   4'd3, 3'b010, 8'h25, 4, 5, 6, 7, 2'b00, -1, 0, 0);
    vecs[1] = mk(2'b10, 32'h38,   4'd3, 3'b010, 8'h11, 14, 15, 12, 13, 2'b00, -1, 0, 0);
    vecs[2] = mk(2'b00, 32'h24,   4'd2, 3'b010, 8'h42, 9, 9, 9, 0, 2'b00, -1, 0, 0);
    vecs[3] = mk(2'b11, 32'h40,   4'd1, 3'b010, 8'h5A, 16, 17, 0, 0, 2'b10, -1, 0, 1);
    vecs[4] = mk(2'b01, 32'hFFFC, 4'd1, 3'b010, 8'h01, 16383, 0, 0, 0, 2'b00, -1, 0, 0);
    vecs[5] = mk(2'b10, 32'h18,   4'd2, 3'b010, 8'h66, 6, 7, 8, 0, 2'b00, -1, 0, 0);
    vecs[6] = mk(2'b01, 32'h08,   4'd0, 3'b000, 8'h99, 2, 0, 0, 0, 2'b00, -1, 0, 0);
    vecs[7] = mk(2'b01, 32'h100,  4'd3, 3'b010, 8'hC3, 64, 65, 66, 67, 2'b00, 1, 5, 0);
    vecs[8] = mk(2'b10, 32'h14,   4'd1, 3'b010, 8'h7E, 5, 4, 0, 0, 2'b00, -1, 0, 0);

    rst = 1'b0; ARID_S = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'b010;
    ARBURST = 2'b01; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_arready", {31'b0, ARREADY}, 0);
    chk("rst_rvalid", {31'b0, RVALID}, 0);
    chk("rst_mem_cs", {31'b0, mem_cs}, 0);
    chk("rst_rdata", RDATA, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("arready_post_rst", {31'b0, ARREADY}, 1);

    for (int i = 0; i < 9; i++) run_burst(vecs[i]);

    // Reset in the middle of beat 2 of a 4-beat burst.
    ARID_S = 8'h77; ARADDR = 32'h80; ARLEN = 4'd3; ARBURST = 2'b01;
    ARVALID = 1'b1; RREADY = 1'b1;
    @(posedge clk); #1; ARVALID = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_rvalid", {31'b0, RVALID}, 1);
    chk("pre_rst_rdata", RDATA, pat(14'd33));
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_rvalid", {31'b0, RVALID}, 0);
    chk("mid_rst_rlast", {31'b0, RLAST}, 0);
    chk("mid_rst_rdata", RDATA, 0);
    chk("mid_rst_rid", {24'b0, RID_S}, 0);
    chk("mid_rst_rresp", {30'b0, RRESP}, 0);
    chk("mid_rst_cs", {30'b0, mem_cs, mem_oe}, 0);
    chk("mid_rst_addr", {18'b0, mem_addr}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("arready_post_mid_rst", {31'b0, ARREADY}, 1);
    run_burst(mk(2'b01, 32'h44, 4'd0, 3'b010, 8'h3C, 17, 0, 0, 0, 2'b00, -1, 0, 0));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
